taillight_sequencer: RTL and testbench
======================================

Name: taillight_sequencer

Overview:
Parametrised turn-signal/hazard/brake sequencer driving two banks of LAMPS lamps each (left, right) from a free-running divided tick. It generalises the fixed 3+3 lamp turn indicator: lamp count and step rate are parameters, and it adds a blank step, an explicit hazard flash, and brake overlay. It sits between debounced driver controls and the LED/lamp drivers.

Parameters:
LAMPS, 3, lamps per side (>=1); the sequence has LAMPS lit steps plus 1 blank step.
TICK_DIV, 16777216, CLOCK_50 cycles per sequencer step (>=2).

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
left_req  in  1  left turn request, level, synchronous to CLOCK_50
right_req  in  1  right turn request, level
haz_req  in  1  hazard request, level
brake  in  1  brake pedal, level
lamps_left  out  LAMPS  left bank; bit0 innermost, bit LAMPS-1 outermost
lamps_right  out  LAMPS  right bank; bit0 innermost
mode  out  2  00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZ
step  out  $clog2(LAMPS+1)  current step index, 0 = blank
tick  out  1  one-cycle step strobe

Behaviour:
- Reset (async assert, sync release): divider=0, tick=0, mode=IDLE, step=0, lamps_left=lamps_right=0, haz phase=off.
- Divider: counts 0..TICK_DIV-1, wraps; tick=1 for exactly the cycle where divider==TICK_DIV-1. First tick at cycle TICK_DIV-1 after reset release.
- FSM advances only on tick cycles; requests are sampled only then. Requests held between ticks have no effect until the next tick.
- Request decode at tick, priority: haz_req or (left_req and right_req) -> HAZ; else left_req -> LEFT; else right_req -> RIGHT; else IDLE.
- LEFT/RIGHT stepping: on entering from another mode, step=1. While the same side remains requested: step 1,2,..,LAMPS,0,1,... (0 is the blank step; wrap LAMPS->0->1).
- Side switch (LEFT<->RIGHT) mid-sequence: next tick goes to the new side at step=1; the old side goes dark immediately.
- Request dropped mid-sequence: next tick goes to IDLE, step=0 (no completion of the sweep).
- HAZ: entry sets phase=on; each further tick in HAZ toggles the phase. step=0 in HAZ. Leaving HAZ clears the phase.
- Lamp pattern (signalling side): step k>0 lights bits [k-1:0] (thermometer, inner to outer); step 0 is all off. Non-signalling side is all off.
- HAZ pattern: both banks all ones when phase=on, all zeros when phase=off.
- Brake overlay, applied every clock (not tick-gated): IDLE+brake -> both banks all ones; LEFT+brake -> right bank all ones, left keeps sequence; RIGHT+brake -> left bank all ones; HAZ ignores brake.
- Outputs are registered: lamps, mode and step reflect the state/brake of the previous cycle (1-cycle latency from a tick or brake edge to the pin).
- LAMPS=1: sequence is on/blank alternation. The step width must hold LAMPS.
- Reset mid-sequence: all outputs drop to 0 asynchronously; the divider restarts from 0.

Test Plan:
- LAMPS=3, TICK_DIV=4, left_req=1 held: tick every 4 cycles; lamps_left = 001,011,111,000,001...; lamps_right=000; mode=01.
- LAMPS=3, TICK_DIV=4, right_req=1, switch to left_req=1 at step 2 (lamps_right=011): next tick -> lamps_right=000, lamps_left=001, step=1.
- left_req=right_req=1 for 4 ticks: mode=11, both banks 111,000,111,000; add brake=1: the pattern is unchanged.
- Idle, brake pulse of 1 cycle between ticks: both banks 111 exactly one cycle after brake rises, then 000 one cycle after it falls; mode stays 00.
- LAMPS=5, TICK_DIV=2, left_req=1 with brake=1: lamps_right=11111 constant; lamps_left steps 00001..11111, 00000; step wraps 5->0->1.
- Assert RESET mid-sequence (lamps_left=011) between clock edges: outputs go 0 without a clock edge; after release, the first tick occurs TICK_DIV-1 cycles later and the sequence resumes at step 1 if left_req is still held.

Source files
------------

// File: rtl/taillight_sequencer.sv
// Turn / hazard / brake lamp sequencer for two banks of LAMPS lamps.
// State advances on a divided tick; brake overlay is applied every clock.
module taillight_sequencer #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 16777216
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic                         left_req,
  input  logic                         right_req,
  input  logic                         haz_req,
  input  logic                         brake,
  output logic [LAMPS-1:0]             lamps_left,
  output logic [LAMPS-1:0]             lamps_right,
  output logic [1:0]                   mode,
  output logic [$clog2(LAMPS+1)-1:0]   step,
  output logic                         tick
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    HAZ   = 2'b11
  } mode_t;

  logic [DW-1:0]    div_reg;
  mode_t            mode_reg, mode_next, req_mode;
  logic [SW-1:0]    step_reg, step_next;
  logic             phase_reg, phase_next;
  logic [LAMPS-1:0] seq;
  logic [LAMPS-1:0] left_next, right_next;
  logic [LAMPS-1:0] left_reg, right_reg;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DW'(1);
    end
  end

  assign tick = (div_reg == DIV_LAST);

  // State register; lamp registers sit here too so lamps track the next state
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mode_reg  <= IDLE;
      step_reg  <= '0;
      phase_reg <= 1'b0;
      left_reg  <= '0;
      right_reg <= '0;
    end else begin
      mode_reg  <= mode_next;
      step_reg  <= step_next;
      phase_reg <= phase_next;
      left_reg  <= left_next;
      right_reg <= right_next;
    end
  end

  always_comb begin
    if (haz_req || (left_req && right_req)) begin
      req_mode = HAZ;
    end else if (left_req) begin
      req_mode = LEFT;
    end else if (right_req) begin
      req_mode = RIGHT;
    end else begin
      req_mode = IDLE;
    end
  end

  always_comb begin
    mode_next  = mode_reg;
    step_next  = step_reg;
    phase_next = phase_reg;
    if (tick) begin
      mode_next = req_mode;
      case (req_mode)
        LEFT, RIGHT: begin
          phase_next = 1'b0;
          if (mode_reg != req_mode) begin
            step_next = SW'(1);
          end else if (step_reg == STEP_LAST) begin
            step_next = '0;
          end else begin
            step_next = step_reg + SW'(1);
          end
        end
        HAZ: begin
          step_next  = '0;
          phase_next = (mode_reg == HAZ) ? ~phase_reg : 1'b1;
        end
        default: begin
          step_next  = '0;
          phase_next = 1'b0;
        end
      endcase
    end
  end

  // Thermometer fill from the inner lamp outward; step 0 is the blank step
  generate
    for (genvar gi = 0; gi < LAMPS; gi++) begin : g_seq
      assign seq[gi] = (step_next > SW'(gi));
    end
  endgenerate

  always_comb begin
    left_next  = '0;
    right_next = '0;
    case (mode_next)
      IDLE: begin
        if (brake) begin
          left_next  = '1;
          right_next = '1;
        end
      end
      LEFT: begin
        left_next = seq;
        if (brake) right_next = '1;
      end
      RIGHT: begin
        right_next = seq;
        if (brake) left_next = '1;
      end
      default: begin
        if (phase_next) begin
          left_next  = '1;
          right_next = '1;
        end
      end
    endcase
  end

  assign lamps_left  = left_reg;
  assign lamps_right = right_reg;
  assign mode        = mode_reg;
  assign step        = step_reg;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Scoreboard bench for taillight_sequencer: a 3-lamp/div-4 and a 5-lamp/div-2
// instance share clock and reset; expectations come from the intended sequences.
module tb_taillight_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic l3, r3, h3, b3;
  logic l5, r5, h5, b5;
  logic [2:0] ll3, lr3;
  logic [1:0] md3;
  logic [1:0] st3;
  logic       tick3;
  logic [4:0] ll5, lr5;
  logic [1:0] md5;
  logic [2:0] st5;
  logic       tick5;

  taillight_sequencer #(.LAMPS(3), .TICK_DIV(4)) dut3 (
    .CLOCK_50(clk), .RESET(rst), .left_req(l3), .right_req(r3), .haz_req(h3),
    .brake(b3), .lamps_left(ll3), .lamps_right(lr3), .mode(md3), .step(st3),
    .tick(tick3)
  );

  taillight_sequencer #(.LAMPS(5), .TICK_DIV(2)) dut5 (
    .CLOCK_50(clk), .RESET(rst), .left_req(l5), .right_req(r5), .haz_req(h5),
    .brake(b5), .lamps_left(ll5), .lamps_right(lr5), .mode(md5), .step(st5),
    .tick(tick5)
  );

  typedef struct packed {
    logic [4:0] ll;
    logic [4:0] lr;
    logic [1:0] md;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(logic [4:0] ll, logic [4:0] lr, logic [1:0] md, logic [2:0] st);
    mk = {ll, lr, md, st};
  endfunction

  function automatic exp_t actual(int which);
    if (which == 3) actual = {2'b00, ll3, 2'b00, lr3, md3, 1'b0, st3};
    else            actual = {ll5, lr5, md5, st5};
  endfunction

  // Wait (bounded) for the next tick, then one more negedge so the result is visible
  task automatic wait_tick(input int which, output int cyc);
    cyc = 0;
    while (cyc < 64) begin
      if ((which == 3) ? tick3 : tick5) begin
        @(negedge clk);
        cyc++;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    cyc = -1;
  endtask

  // Apply {left,right,haz,brake} to one instance, let one tick pass, return outputs
  task automatic drive(input int which, input logic [3:0] stim, output exp_t act, output int cyc);
    if (which == 3) {l3, r3, h3, b3} = stim;
    else            {l5, r5, h5, b5} = stim;
    wait_tick(which, cyc);
    act = actual(which);
    $display("dut%0d stim=%b cyc=%0d ll=%b lr=%b md=%b st=%0d",
             which, stim, cyc, act.ll, act.lr, act.md, act.st);
  endtask

  task automatic test_reset();
    int f3, f5;
    exp_t act;
    rst = 1'b1;
    {l3, r3, h3, b3} = 4'b0;
    {l5, r5, h5, b5} = 4'b0;
    @(negedge clk);
    @(negedge clk);
    sb.push_back(mk(0, 0, 0, 0));
    act = actual(3);
    n_vec++;
    if (act !== sb.pop_front() || tick3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset3 got %h tick=%b want 0000 tick=0", act, tick3);
    end
    sb.push_back(mk(0, 0, 0, 0));
    act = actual(5);
    n_vec++;
    if (act !== sb.pop_front() || tick5 !== 1'b0) begin
      n_err++;
      $display("FAIL reset5 got %h tick=%b want 0000 tick=0", act, tick5);
    end
    rst = 1'b0;
    f3 = -1;
    f5 = -1;
    for (int n = 0; n < 10; n++) begin
      if (tick3 && f3 < 0) f3 = n;
      if (tick5 && f5 < 0) f5 = n;
      @(negedge clk);
    end
    n_vec++;
    if (f3 != 3) begin n_err++; $display("FAIL first_tick3 got %0d want 3", f3); end
    n_vec++;
    if (f5 != 1) begin n_err++; $display("FAIL first_tick5 got %0d want 1", f5); end
    $display("reset done first_tick3=%0d first_tick5=%0d", f3, f5);
  endtask

  task automatic test_left();
    exp_t tbl[5];
    exp_t act, e;
    int cyc;
    tbl[0] = mk(5'b00001, 0, 2'b01, 1);
    tbl[1] = mk(5'b00011, 0, 2'b01, 2);
    tbl[2] = mk(5'b00111, 0, 2'b01, 3);
    tbl[3] = mk(5'b00000, 0, 2'b01, 0);
    tbl[4] = mk(5'b00001, 0, 2'b01, 1);
    for (int j = 0; j < 5; j++) begin
      sb.push_back(tbl[j]);
      drive(3, 4'b1000, act, cyc);
      e = sb.pop_front();
      n_vec++;
      if (cyc < 0 || act !== e) begin
        n_err++;
        $display("FAIL left_seq[%0d] got %h cyc=%0d want %h", j, act, cyc, e);
      end
      if (j > 0) begin
        n_vec++;
        if (cyc != 4) begin n_err++; $display("FAIL tick_period3 got %0d want 4", cyc); end
      end
    end
  endtask

  task automatic test_switch();
    exp_t tbl[4];
    logic [3:0] stim[4];
    exp_t act, e;
    int cyc;
    stim[0] = 4'b0100; tbl[0] = mk(0, 5'b00001, 2'b10, 1);
    stim[1] = 4'b0100; tbl[1] = mk(0, 5'b00011, 2'b10, 2);
    stim[2] = 4'b1000; tbl[2] = mk(5'b00001, 0, 2'b01, 1);
    stim[3] = 4'b0000; tbl[3] = mk(0, 0, 2'b00, 0);
    for (int j = 0; j < 4; j++) begin
      sb.push_back(tbl[j]);
      drive(3, stim[j], act, cyc);
      e = sb.pop_front();
      n_vec++;
      if (cyc < 0 || act !== e) begin
        n_err++;
        $display("FAIL switch[%0d] got %h cyc=%0d want %h", j, act, cyc, e);
      end
    end
  endtask

  task automatic test_hazard();
    exp_t tbl[10];
    logic [3:0] stim[10];
    exp_t act, e;
    int cyc;
    for (int j = 0; j < 4; j++) begin
      stim[j] = 4'b1100;
      tbl[j]  = (j % 2 == 0) ? mk(5'b00111, 5'b00111, 2'b11, 0) : mk(0, 0, 2'b11, 0);
    end
    stim[4] = 4'b1101; tbl[4] = mk(5'b00111, 5'b00111, 2'b11, 0);
    stim[5] = 4'b1101; tbl[5] = mk(0, 0, 2'b11, 0);
    stim[6] = 4'b0010; tbl[6] = mk(5'b00111, 5'b00111, 2'b11, 0);
    stim[7] = 4'b0000; tbl[7] = mk(0, 0, 2'b00, 0);
    stim[8] = 4'b0010; tbl[8] = mk(5'b00111, 5'b00111, 2'b11, 0);
    stim[9] = 4'b0000; tbl[9] = mk(0, 0, 2'b00, 0);
    for (int j = 0; j < 10; j++) begin
      sb.push_back(tbl[j]);
      drive(3, stim[j], act, cyc);
      e = sb.pop_front();
      n_vec++;
      if (cyc < 0 || act !== e) begin
        n_err++;
        $display("FAIL hazard[%0d] got %h cyc=%0d want %h", j, act, cyc, e);
      end
      if (j == 3) begin
        // brake rises mid-step while the flash is in its off phase
        b3 = 1'b1;
        @(negedge clk);
        sb.push_back(mk(0, 0, 2'b11, 0));
        act = actual(3);
        e = sb.pop_front();
        n_vec++;
        if (act !== e) begin
          n_err++;
          $display("FAIL hazard_brake got %h want %h", act, e);
        end
      end
    end
  endtask

  task automatic test_brake_idle();
    exp_t act, e;
    int cyc;
    drive(3, 4'b0000, act, cyc);
    b3 = 1'b1;
    sb.push_back(mk(0, 0, 2'b00, 0));
    act = actual(3);
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL brake_pre_edge got %h want %h", act, e); end
    @(negedge clk);
    sb.push_back(mk(5'b00111, 5'b00111, 2'b00, 0));
    act = actual(3);
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL brake_on got %h want %h", act, e); end
    b3 = 1'b0;
    @(negedge clk);
    sb.push_back(mk(0, 0, 2'b00, 0));
    act = actual(3);
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL brake_off got %h want %h", act, e); end
    $display("brake pulse checked");
  endtask

  task automatic test_left_brake5();
    exp_t tbl[7];
    exp_t act, e;
    int cyc;
    tbl[0] = mk(5'b00001, 5'b11111, 2'b01, 1);
    tbl[1] = mk(5'b00011, 5'b11111, 2'b01, 2);
    tbl[2] = mk(5'b00111, 5'b11111, 2'b01, 3);
    tbl[3] = mk(5'b01111, 5'b11111, 2'b01, 4);
    tbl[4] = mk(5'b11111, 5'b11111, 2'b01, 5);
    tbl[5] = mk(5'b00000, 5'b11111, 2'b01, 0);
    tbl[6] = mk(5'b00001, 5'b11111, 2'b01, 1);
    for (int j = 0; j < 7; j++) begin
      sb.push_back(tbl[j]);
      drive(5, 4'b1001, act, cyc);
      e = sb.pop_front();
      n_vec++;
      if (cyc < 0 || act !== e) begin
        n_err++;
        $display("FAIL left_brake5[%0d] got %h cyc=%0d want %h", j, act, cyc, e);
      end
      if (j > 0) begin
        n_vec++;
        if (cyc != 2) begin n_err++; $display("FAIL tick_period5 got %0d want 2", cyc); end
      end
    end
    sb.push_back(mk(0, 0, 2'b00, 0));
    drive(5, 4'b0000, act, cyc);
    e = sb.pop_front();
    n_vec++;
    if (cyc < 0 || act !== e) begin n_err++; $display("FAIL idle5 got %h want %h", act, e); end
  endtask

  task automatic test_reset_mid();
    exp_t act, e;
    int cyc, n;
    sb.push_back(mk(5'b00001, 0, 2'b01, 1));
    sb.push_back(mk(5'b00011, 0, 2'b01, 2));
    for (int j = 0; j < 2; j++) begin
      drive(3, 4'b1000, act, cyc);
      e = sb.pop_front();
      n_vec++;
      if (cyc < 0 || act !== e) begin n_err++; $display("FAIL pre_reset[%0d] got %h want %h", j, act, e); end
    end
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk(0, 0, 2'b00, 0));
    act = actual(3);
    e = sb.pop_front();
    n_vec++;
    if (act !== e || tick3 !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got %h tick=%b want %h tick=0", act, tick3, e);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!tick3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n != 3) begin n_err++; $display("FAIL restart_tick got %0d want 3", n); end
    @(negedge clk);
    sb.push_back(mk(5'b00001, 0, 2'b01, 1));
    act = actual(3);
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL resume got %h want %h", act, e); end
    $display("reset mid-sequence restart_tick=%0d ll=%b", n, act.ll);
    sb.push_back(mk(0, 0, 2'b00, 0));
    drive(3, 4'b0000, act, cyc);
    e = sb.pop_front();
    n_vec++;
    if (cyc < 0 || act !== e) begin n_err++; $display("FAIL final_idle got %h want %h", act, e); end
  endtask

  initial begin
    test_reset();
    test_left();
    test_switch();
    test_hazard();
    test_brake_idle();
    test_left_brake5();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
